// File: rtl/prim_reg_pkg.sv
// Shared register-access definitions: software access semantics per register.
package prim_reg_pkg;

    typedef enum logic [2:0] {
        SwAccessRW  = 3'd0,
        SwAccessRO  = 3'd1,
        SwAccessWO  = 3'd2,
        SwAccessW1C = 3'd3,
        SwAccessW1S = 3'd4,
        SwAccessW0C = 3'd5,
        SwAccessRC  = 3'd6
    } sw_access_e;

endpackage

// File: rtl/prim_reg_resp_bank.sv
// Software/hardware register bank enforcing per-register sw_access_e semantics.
// Optional feature: PRIM_REG_RESP_BANK_WRITE_ERR_EN flags writes to RO/RC registers as errors.
module prim_reg_resp_bank
    import prim_reg_pkg::*;
#(
    parameter int unsigned NumRegs = 8,
    parameter int unsigned DataW   = 32,
    parameter int unsigned AddrW   = (NumRegs > 1) ? $clog2(NumRegs) : 1,
    parameter sw_access_e [NumRegs-1:0] SwAccess = {NumRegs{SwAccessRW}},
    parameter logic [NumRegs*DataW-1:0] ResetVal = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic                     we_i,
    input  logic [AddrW-1:0]         addr_i,
    input  logic [DataW-1:0]         wdata_i,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    output logic [DataW-1:0]         rdata_o,
    output logic                     rerr_o,
    input  logic [NumRegs-1:0]       hw_de_i,
    input  logic [NumRegs*DataW-1:0] hw_d_i,
    output logic [NumRegs*DataW-1:0] q_o,
    output logic [NumRegs-1:0]       qe_o,
    output logic [NumRegs-1:0]       re_o
);

`ifdef PRIM_REG_RESP_BANK_WRITE_ERR_EN
    localparam bit WriteErrEn = 1'b1;
`else
    localparam bit WriteErrEn = 1'b0;
`endif

    localparam int unsigned NumAddr = 1 << AddrW;

    logic [NumRegs-1:0][DataW-1:0] q_q, q_d;
    logic [NumRegs-1:0]            qe_q, qe_d;
    logic [NumRegs-1:0]            re_q, re_d;
    logic                          rvalid_q, rvalid_d;
    logic [DataW-1:0]              rdata_q, rdata_d;
    logic                          rerr_q, rerr_d;

    logic                          accept_c;
    logic                          in_range_c;
    sw_access_e                    acc_c;
    logic [DataW-1:0]              rd_val_c;
    logic [NumAddr-1:0]            addr_valid;

    // Address decode table; avoids comparing a narrow address against NumRegs.
    for (genvar k = 0; k < NumAddr; k++) begin : g_valid
        assign addr_valid[k] = (k < NumRegs);
    end

    assign gnt_o    = !rvalid_q || rready_i;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign rerr_o   = rerr_q;
    assign q_o      = q_q;
    assign qe_o     = qe_q;
    assign re_o     = re_q;

    always_comb begin
        accept_c   = req_i && gnt_o;
        in_range_c = addr_valid[addr_i];
        acc_c      = SwAccessRW;
        rd_val_c   = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (addr_i == AddrW'(i)) begin
                acc_c    = SwAccess[i];
                rd_val_c = q_q[i];
            end
        end
    end

    // Register update: hardware load is the base, the software op is applied on top.
    always_comb begin
        q_d  = q_q;
        qe_d = '0;
        re_d = '0;
        for (int i = 0; i < NumRegs; i++) begin
            logic [DataW-1:0] base;
            logic             sel;
            base   = hw_de_i[i] ? hw_d_i[i*DataW +: DataW] : q_q[i];
            sel    = accept_c && in_range_c && (addr_i == AddrW'(i));
            q_d[i] = base;
            if (sel && we_i) begin
                unique case (SwAccess[i])
                    SwAccessRW, SwAccessWO: begin
                        q_d[i]  = wdata_i;
                        qe_d[i] = 1'b1;
                    end
                    SwAccessW1C: begin
                        q_d[i]  = base & ~wdata_i;
                        qe_d[i] = 1'b1;
                    end
                    SwAccessW1S: begin
                        q_d[i]  = base | wdata_i;
                        qe_d[i] = 1'b1;
                    end
                    SwAccessW0C: begin
                        q_d[i]  = base & wdata_i;
                        qe_d[i] = 1'b1;
                    end
                    default: ;
                endcase
            end else if (sel) begin
                re_d[i] = 1'b1;
                // A coincident hardware event must survive the read-clear.
                if (SwAccess[i] == SwAccessRC && !hw_de_i[i]) begin
                    q_d[i] = '0;
                end
            end
        end
    end

    // Response channel: one outstanding response, held until consumed.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        if (accept_c) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rerr_d   = 1'b0;
            if (!in_range_c) begin
                rerr_d = 1'b1;
            end else if (we_i) begin
                rerr_d = WriteErrEn && (acc_c == SwAccessRO || acc_c == SwAccessRC);
            end else if (acc_c != SwAccessWO) begin
                rdata_d = rd_val_c;
            end
        end else if (rvalid_q && rready_i) begin
            rvalid_d = 1'b0;
            rdata_d  = '0;
            rerr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q      <= ResetVal;
            qe_q     <= '0;
            re_q     <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            q_q      <= q_d;
            qe_q     <= qe_d;
            re_q     <= re_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

endmodule

// File: tb/tb_prim_reg_resp_bank.sv
// Self-checking bench for prim_reg_resp_bank: directed test-plan steps then random traffic vs a reference model.
module tb_prim_reg_resp_bank;
    import prim_reg_pkg::*;

    localparam int unsigned NR = 7;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;
    localparam sw_access_e [NR-1:0] Acc = {SwAccessRC, SwAccessW0C, SwAccessW1S, SwAccessW1C,
                                           SwAccessWO, SwAccessRO, SwAccessRW};
    localparam logic [NR*DW-1:0] RstVal = {32'h0, 32'h0, 32'h0000_00F0, 32'h0,
                                           32'h0, 32'h0, 32'hA5A5_0000};
`ifdef PRIM_REG_RESP_BANK_WRITE_ERR_EN
    localparam bit WErr = 1'b1;
`else
    localparam bit WErr = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic req, gnt, we, rvalid, rready, rerr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic [NR-1:0] hw_de, qe, re;
    logic [NR*DW-1:0] hw_d, q;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mq [NR];
    logic          mvalid;
    logic [DW-1:0] mrdata;
    logic          mrerr;
    logic [NR-1:0] eqe, ere;

    always #5 clk = ~clk;

    prim_reg_resp_bank #(
        .NumRegs (NR),
        .DataW   (DW),
        .AddrW   (AW),
        .SwAccess(Acc),
        .ResetVal(RstVal)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .gnt_o   (gnt),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rvalid_o(rvalid),
        .rready_i(rready),
        .rdata_o (rdata),
        .rerr_o  (rerr),
        .hw_de_i (hw_de),
        .hw_d_i  (hw_d),
        .q_o     (q),
        .qe_o    (qe),
        .re_o    (re)
    );

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] mq_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = mq[i];
        return v;
    endfunction

    function automatic logic [NR*DW-1:0] hv(input int idx, input logic [DW-1:0] val);
        logic [NR*DW-1:0] v;
        v = '0;
        v[idx*DW +: DW] = val;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mq[i] = RstVal[i*DW +: DW];
        mvalid = 1'b0;
        mrdata = '0;
        mrerr  = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict from the access rules, check outputs.
    task automatic step(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [NR-1:0] de, input logic [NR*DW-1:0] hd, input logic rr);
        logic [DW-1:0] nq [NR];
        logic          exp_gnt, acc;
        logic [DW-1:0] base, old;
        @(negedge clk);
        req = r; we = w; addr = a; wdata = wd; hw_de = de; hw_d = hd; rready = rr;
        #1;
        exp_gnt = !mvalid || rr;
        chk("gnt", 224'(gnt), 224'(exp_gnt));
        acc = r && exp_gnt;
        eqe = '0;
        ere = '0;
        for (int i = 0; i < NR; i++) nq[i] = de[i] ? hd[i*DW +: DW] : mq[i];
        if (acc) begin
            mvalid = 1'b1;
            mrdata = '0;
            mrerr  = 1'b0;
            if (int'(a) >= NR) begin
                mrerr = 1'b1;
            end else begin
                old  = mq[a];
                base = nq[a];
                if (w) begin
                    case (Acc[a])
                        SwAccessRW, SwAccessWO: begin nq[a] = wd;          eqe[a] = 1'b1; end
                        SwAccessW1C:            begin nq[a] = base & ~wd;  eqe[a] = 1'b1; end
                        SwAccessW1S:            begin nq[a] = base | wd;   eqe[a] = 1'b1; end
                        SwAccessW0C:            begin nq[a] = base & wd;   eqe[a] = 1'b1; end
                        default:                mrerr = WErr;
                    endcase
                end else begin
                    ere[a] = 1'b1;
                    mrdata = (Acc[a] == SwAccessWO) ? '0 : old;
                    if (Acc[a] == SwAccessRC && !de[a]) nq[a] = '0;
                end
            end
        end else if (mvalid && rr) begin
            mvalid = 1'b0;
        end
        for (int i = 0; i < NR; i++) mq[i] = nq[i];
        @(posedge clk);
        #1;
        chk("rvalid", 224'(rvalid), 224'(mvalid));
        if (mvalid) begin
            chk("rdata", 224'(rdata), 224'(mrdata));
            chk("rerr", 224'(rerr), 224'(mrerr));
        end
        chk("q", q, mq_vec());
        chk("qe", 224'(qe), 224'(eqe));
        chk("re", 224'(re), 224'(ere));
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; hw_de = '0; hw_d = '0; rready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", q, RstVal);
        chk("rst_q0", 224'(q[DW-1:0]), 224'(32'hA5A5_0000));
        chk("rst_rvalid", 224'(rvalid), 224'(0));
        chk("rst_rdata", 224'(rdata), 224'(0));
        chk("rst_rerr", 224'(rerr), 224'(0));
        chk("rst_qe", 224'(qe), 224'(0));
        chk("rst_re", 224'(re), 224'(0));
        chk("rst_gnt", 224'(gnt), 224'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset value readback
        step(1, 0, 3'd0, '0, '0, '0, 1);
        chk("tp_rd0", 224'(rdata), 224'(32'hA5A5_0000));
        chk("tp_re0", 224'(re), 224'(7'b0000001));

        // W1C with and without a coincident hardware load
        step(0, 0, 3'd0, '0, 7'b0001000, hv(3, 32'hFF), 1);
        step(1, 1, 3'd3, 32'h0F, '0, '0, 1);
        chk("tp_w1c", 224'(q[3*DW +: DW]), 224'(32'hF0));
        step(0, 0, 3'd0, '0, 7'b0001000, hv(3, 32'hFF), 1);
        step(1, 1, 3'd3, 32'h0F, 7'b0001000, hv(3, 32'h1FF), 1);
        chk("tp_w1c_hw", 224'(q[3*DW +: DW]), 224'(32'h1F0));

        // Read-clear with and without a coincident hardware event
        step(0, 0, 3'd0, '0, 7'b1000000, hv(6, 32'h3C), 1);
        step(1, 0, 3'd6, '0, '0, '0, 1);
        chk("tp_rc_rd", 224'(rdata), 224'(32'h3C));
        chk("tp_rc_q", 224'(q[6*DW +: DW]), 224'(0));
        step(0, 0, 3'd0, '0, 7'b1000000, hv(6, 32'h3C), 1);
        step(1, 0, 3'd6, '0, 7'b1000000, hv(6, 32'h5), 1);
        chk("tp_rc_hw_rd", 224'(rdata), 224'(32'h3C));
        chk("tp_rc_hw_q", 224'(q[6*DW +: DW]), 224'(32'h5));

        // RO write, WO read, out-of-range access
        step(1, 1, 3'd1, 32'h1234, '0, '0, 1);
        chk("tp_ro_err", 224'(rerr), 224'(WErr));
        step(1, 1, 3'd2, 32'hDEAD_BEEF, '0, '0, 1);
        step(1, 0, 3'd2, '0, '0, '0, 1);
        chk("tp_wo_rd", 224'(rdata), 224'(0));
        step(1, 0, 3'd7, '0, '0, '0, 1);
        chk("tp_oor_rerr", 224'(rerr), 224'(1));
        step(1, 1, 3'd7, 32'hFFFF_FFFF, '0, '0, 1);

        // Stalled response, then back-to-back accept on consume
        step(1, 0, 3'd0, '0, '0, '0, 0);
        step(0, 0, 3'd0, '0, '0, '0, 0);
        step(1, 1, 3'd0, 32'h55, '0, '0, 0);
        step(0, 0, 3'd0, '0, '0, '0, 0);
        chk("tp_stall_gnt", 224'(gnt), 224'(0));
        step(1, 0, 3'd4, '0, '0, '0, 1);
        chk("tp_b2b_rd", 224'(rdata), 224'(32'hF0));

        // Reset while a response is pending
        step(1, 0, 3'd0, '0, '0, '0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("tp_rst_rvalid", 224'(rvalid), 224'(0));
        model_reset();
        chk("tp_rst_q", q, RstVal);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            logic [NR*DW-1:0] hd;
            logic [NR-1:0]    de;
            for (int i = 0; i < NR; i++) hd[i*DW +: DW] = $urandom;
            de = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
            step(($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom), $urandom, de, hd,
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prim_reg_resp_bank.md
# prim_reg_resp_bank

Software-facing register bank that implements the `sw_access_e` access semantics for `NumRegs` registers, each with a per-register access specifier. It answers one-outstanding read/write requests from a bus adapter and exposes register values and update strobes to hardware, which can also load registers. It is the responder end of the register access contract: the access specifiers define the rules, and this block enforces them on every access.

## Interface
Parameters:
- `NumRegs`, 8, number of registers (≥1)
- `DataW`, 32, register width
- `AddrW`, `$clog2(NumRegs)` (min 1), word address width
- `SwAccess`, all `SwAccessRW`, packed array `[NumRegs-1:0]` of `prim_reg_pkg::sw_access_e`, access type per register
- `ResetVal`, `'0`, `[NumRegs*DataW-1:0]` reset value per register (reg i at bits `i*DataW +: DataW`)

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `req_i` in 1: request valid
- `gnt_o` out 1: request accepted when `req_i && gnt_o`
- `we_i` in 1: 1 = write, 0 = read
- `addr_i` in AddrW: register index
- `wdata_i` in DataW: write data
- `rvalid_o` out 1: response valid
- `rready_i` in 1: response consumed when `rvalid_o && rready_i`
- `rdata_o` out DataW: read data (0 for writes)
- `rerr_o` out 1: access error
- `hw_de_i` in NumRegs: hardware load enable per register
- `hw_d_i` in NumRegs*DataW: hardware load data
- `q_o` out NumRegs*DataW: current register values
- `qe_o` out NumRegs: one-cycle pulse, register written by software
- `re_o` out NumRegs: one-cycle pulse, register read by software

## Operation
- `gnt_o = !rvalid_o || rready_i` (combinational); at most one response pending.
- On accept, per `SwAccess[addr_i]`:
  - RW: write `q = wdata`; read returns `q`.
  - RO: write ignored, `rerr=1` (see Configuration); read returns `q`.
  - WO: write `q = wdata`; read returns 0, `rerr=0`.
  - W1C: `q = q & ~wdata`; W1S: `q = q | wdata`; W0C: `q = q & wdata`; reads return `q`.
  - RC: read returns `q`, then `q = 0`; write ignored, `rerr=1` (see Configuration).
- `addr_i >= NumRegs`: `rdata=0`, `rerr=1` always, no state change, no strobes.
- `rdata_o` carries the value before this access's update.
- Simultaneous `hw_de_i[i]` and software access to reg i:
  - RW/WO write: software wins.
  - W1C/W1S/W0C write: software op applied to `hw_d` (e.g. W1C: `hw_d & ~wdata`).
  - RC read: `hw_d` wins (event not lost); rdata is old `q`.
  - RO/RC write: `hw_d` loaded.
- `hw_de_i` without software access: `q = hw_d` for any type.
- `qe_o[i]` pulses only for writes that change or may change state (RW, WO, W1C, W1S, W0C). `re_o[i]` pulses for any in-range read.

## Timing
- Reset: `q = ResetVal`; `rvalid_o=0`, `rdata_o=0`, `rerr_o=0`, `qe_o=0`, `re_o=0`; `gnt_o=1`.
- Accept at edge N: `rvalid_o`, `rdata_o`, `rerr_o`, new `q_o`, `qe_o`/`re_o` all valid in cycle N+1.
- Response held stable until `rready_i`; back-to-back accept allowed in the cycle the response is consumed (throughput 1/cycle with `rready_i=1`).
- Strobes are exactly one cycle wide, even while a response stalls.
- Reset asserted mid-transaction drops the pending response; no partial update.

## Configuration
- `PRIM_REG_RESP_BANK_WRITE_ERR_EN`: when defined, writes to RO and RC registers return `rerr_o=1`. When undefined, such writes are silently ignored with `rerr_o=0`. Out-of-range errors are unaffected by the macro.

## Test plan
- Reset with `ResetVal` reg0=0xA5A5_0000: `q_o` reg0=0xA5A5_0000, `rvalid_o=0`, `gnt_o=1`; read reg0 → rdata 0xA5A5_0000, rerr 0, `re_o[0]` pulse.
- W1C reg with q=0xFF, write 0x0F → next cycle q=0xF0, `qe_o` pulse; same cycle `hw_de` with `hw_d`=0x1FF → q=0x1F0.
- RC reg q=0x3C: read → rdata 0x3C, q=0 next cycle; repeat with `hw_de` `hw_d`=0x5 → rdata 0x3C, q=0x5.
- Write 0x1234 to RO reg: q unchanged; rerr=1 with macro, 0 without; WO read → rdata 0, rerr 0.
- `addr_i`=NumRegs: rdata 0, rerr 1, no strobes, all `q_o` unchanged.
- Hold `rready_i=0` 3 cycles after a read: `gnt_o=0`, response stable, `re_o` single pulse; raise `rready_i` with new `req_i` → accepted same cycle; reset asserted while `rvalid_o=1` → `rvalid_o=0` immediately.
